// File: rtl/boot_sequencer.sv
// Boot sequencer: copies the microcode, MLU slice and MLU lookahead images from boot EEPROM into SRAM.
// Define BOOT_CHECKSUM_EN to verify the checksum byte stored after each image in ROM.
module boot_sequencer #(
    parameter int CTRL_BYTES      = 4096,
    parameter int SLICE_BYTES     = 65536,
    parameter int LOOKAHEAD_BYTES = 512,
    parameter int READ_WAIT       = 3,
    parameter int ROM_ADDR_W      = 18
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [7:0]            rom_data,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_n_oe,
    output logic [7:0]            data,
    output logic [16:0]           addr,
    output logic                  control_n_we,
    output logic                  mlu_slice_n_we,
    output logic                  mlu_lookahead_n_we,
    output logic [1:0]            region,
    output logic                  n_booted,
    output logic                  err
);

    localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(READ_WAIT - 1);
    localparam logic [16:0]       CTRL_LAST  = 17'(CTRL_BYTES - 1);
    localparam logic [16:0]       SLICE_LAST = 17'(SLICE_BYTES - 1);
    localparam logic [16:0]       LOOK_LAST  = 17'(LOOKAHEAD_BYTES - 1);

    if (CTRL_BYTES < 1 || CTRL_BYTES > 131072 || SLICE_BYTES < 1 || SLICE_BYTES > 131072 ||
        LOOKAHEAD_BYTES < 1 || LOOKAHEAD_BYTES > 131072) begin : g_bad_region_size
        $error("boot_sequencer: every region must hold 1..131072 bytes");
    end
    if (READ_WAIT < 1) begin : g_bad_read_wait
        $error("boot_sequencer: READ_WAIT must be at least 1");
    end

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, WRITE, HOLD, CHECK, DONE, FAIL} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, WRITE, HOLD, DONE} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [16:0]       region_last;
    logic              last_byte;
    logic              read_done;
    logic              reading;
    logic              reading_next;
    logic              next_region;
    logic              rom_step;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum;
    logic [7:0]        sum_final;
`endif

    always_comb begin
        state_next  = state;
        next_region = 1'b0;
        rom_step    = 1'b0;
        read_done   = (wait_cnt == WAIT_LAST);
        case (region)
            2'd0:    region_last = CTRL_LAST;
            2'd1:    region_last = SLICE_LAST;
            default: region_last = LOOK_LAST;
        endcase
        last_byte = (addr == region_last);
`ifdef BOOT_CHECKSUM_EN
        sum_final = sum + rom_data;
        reading   = (state == READ) || (state == CHECK);
`else
        reading   = (state == READ);
`endif
        case (state)
            IDLE:  state_next = READ;
            READ:  if (read_done) state_next = WRITE;
            WRITE: state_next = HOLD;
            HOLD: begin
                rom_step = 1'b1;
                if (!last_byte) begin
                    state_next = READ;
                end else begin
`ifdef BOOT_CHECKSUM_EN
                    state_next = CHECK;
`else
                    next_region = 1'b1;
                    state_next  = (region == 2'd2) ? DONE : READ;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            // The checksum byte is consumed like data but never written to an SRAM.
            CHECK: begin
                if (read_done) begin
                    rom_step = 1'b1;
                    if (sum_final == 8'd0) begin
                        next_region = 1'b1;
                        state_next  = (region == 2'd2) ? DONE : READ;
                    end else begin
                        state_next = FAIL;
                    end
                end
            end
`endif
            default: state_next = state;
        endcase
`ifdef BOOT_CHECKSUM_EN
        reading_next = (state_next == READ) || (state_next == CHECK);
`else
        reading_next = (state_next == READ);
`endif
    end

    // Outputs are registered from the next state so strobes and enables never glitch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= IDLE;
            wait_cnt           <= '0;
            rom_addr           <= '0;
            rom_n_oe           <= 1'b1;
            data               <= 8'd0;
            addr               <= 17'd0;
            control_n_we       <= 1'b1;
            mlu_slice_n_we     <= 1'b1;
            mlu_lookahead_n_we <= 1'b1;
            region             <= 2'd0;
            n_booted           <= 1'b1;
        end else begin
            state              <= state_next;
            rom_n_oe           <= !reading_next;
            control_n_we       <= !(state_next == WRITE && region == 2'd0);
            mlu_slice_n_we     <= !(state_next == WRITE && region == 2'd1);
            mlu_lookahead_n_we <= !(state_next == WRITE && region == 2'd2);
            n_booted           <= (state_next != DONE);
            if (reading) wait_cnt <= read_done ? '0 : wait_cnt + 1'b1;
            if (state == READ && read_done) data <= rom_data;
            if (rom_step) rom_addr <= rom_addr + 1'b1;
            if (next_region) begin
                addr   <= 17'd0;
                region <= region + 2'd1;
            end else if (state == HOLD && !last_byte) begin
                addr <= addr + 1'b1;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running sum restarts with each region; a failed check latches ERR until reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sum <= 8'd0;
            err <= 1'b0;
        end else begin
            if (next_region) sum <= 8'd0;
            else if (state == READ && read_done) sum <= sum + rom_data;
            if (state_next == FAIL) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed self-checking bench for boot_sequencer with tiny regions (4/3/2 bytes, READ_WAIT=2).
// Build with BOOT_CHECKSUM_EN defined to exercise the checksum path instead of the plain copy.
`timescale 1ns/1ps
module tb_boot_sequencer;

    localparam int CTRL  = 4;
    localparam int SLICE = 3;
    localparam int LOOK  = 2;
    localparam int RW    = 2;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic [7:0]    rom_data = 8'd0;
    logic [AW-1:0] rom_addr;
    logic          rom_n_oe;
    logic [7:0]    data;
    logic [16:0]   addr;
    logic          control_n_we;
    logic          mlu_slice_n_we;
    logic          mlu_lookahead_n_we;
    logic [1:0]    region;
    logic          n_booted;
    logic          err;

    logic [7:0]    rom [256];
    int            checks = 0;
    int            failures = 0;
    int            edges;
    int            base;

    boot_sequencer #(
        .CTRL_BYTES(CTRL), .SLICE_BYTES(SLICE), .LOOKAHEAD_BYTES(LOOK),
        .READ_WAIT(RW), .ROM_ADDR_W(AW)
    ) dut (
        .clk(clk), .n_rst(n_rst), .rom_data(rom_data), .rom_addr(rom_addr),
        .rom_n_oe(rom_n_oe), .data(data), .addr(addr),
        .control_n_we(control_n_we), .mlu_slice_n_we(mlu_slice_n_we),
        .mlu_lookahead_n_we(mlu_lookahead_n_we), .region(region),
        .n_booted(n_booted), .err(err)
    );

    always #5 clk = ~clk;

    // Registered EEPROM: an address must be presented for two edges before its data can be sampled.
    always @(posedge clk) rom_data <= rom_n_oe ? 8'h00 : rom[rom_addr];

    logic [1:0]  p_which [128];
    logic [16:0] p_addr  [128];
    logic [7:0]  p_data  [128];
    int          pulse_cnt = 0;
    int          overlap_cnt = 0;
    int          wide_cnt = 0;
    int          unstable_cnt = 0;
    logic        prev_low = 1'b0;
    logic [16:0] prev_addr = 17'd0;
    logic [7:0]  prev_data = 8'd0;
    logic [1:0]  n_low;

    assign n_low = {1'b0, ~control_n_we} + {1'b0, ~mlu_slice_n_we} + {1'b0, ~mlu_lookahead_n_we};

    // Strobe monitor: logs every pulse and tallies overlap, width and bus-stability violations.
    always @(negedge clk) begin
        if (n_low > 2'd1) overlap_cnt <= overlap_cnt + 1;
        if (n_low != 2'd0) begin
            if (prev_low) wide_cnt <= wide_cnt + 1;
            if (addr != prev_addr) unstable_cnt <= unstable_cnt + 1;
            if (pulse_cnt < 128) begin
                p_which[pulse_cnt] <= !control_n_we ? 2'd0 : (!mlu_slice_n_we ? 2'd1 : 2'd2);
                p_addr[pulse_cnt]  <= addr;
                p_data[pulse_cnt]  <= data;
            end
            pulse_cnt <= pulse_cnt + 1;
        end else if (prev_low) begin
            if (addr != prev_addr || data != prev_data) unstable_cnt <= unstable_cnt + 1;
        end
        prev_low  <= (n_low != 2'd0);
        prev_addr <= addr;
        prev_data <= data;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_output({tag, "_data"}, 32'(data), 32'd0);
        check_output({tag, "_addr"}, 32'(addr), 32'd0);
        check_output({tag, "_region"}, 32'(region), 32'd0);
        check_output({tag, "_ctl_bits"},
                     32'({rom_n_oe, control_n_we, mlu_slice_n_we, mlu_lookahead_n_we, n_booted, err}),
                     32'b111110);
    endtask

    // Releases reset on a falling edge and counts rising edges until N_BOOTED falls (or ERR rises).
    task automatic apply_stimulus(output int n_edges, input bit stop_on_err);
        @(negedge clk);
        n_rst = 1'b1;
        n_edges = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (!n_booted || (stop_on_err && err)) begin
                n_edges = i;
                break;
            end
        end
    endtask

    task automatic assert_reset_now();
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
    endtask

    // Byte k of the copy goes to region r at offset k-first(r); checksum bytes shift ROM by r.
    task automatic check_pulses(input string tag, input int b, input bit with_cks);
        check_output({tag, "_pulse_count"}, 32'(pulse_cnt - b), 32'd9);
        for (int k = 0; k < 9; k++) begin
            int r;
            int off;
            logic [26:0] e;
            r   = (k < 4) ? 0 : ((k < 7) ? 1 : 2);
            off = (r == 0) ? 0 : ((r == 1) ? 4 : 7);
            e   = {2'(r), 17'(k - off), 8'(16 + k + (with_cks ? r : 0))};
            check_output($sformatf("%s_pulse%0d", tag, k),
                         32'({p_which[b + k], p_addr[b + k], p_data[b + k]}), 32'(e));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i + 16);
`ifdef BOOT_CHECKSUM_EN
        rom[4]  = 8'hBA;
        rom[8]  = 8'hBE;
        rom[11] = 8'hCD;
`endif
        #3 n_rst = 1'b0;
        #1 check_reset_state("por");
        repeat (3) @(posedge clk);

`ifdef BOOT_CHECKSUM_EN
        $display("[TB] checksum build: valid image");
        base = pulse_cnt;
        apply_stimulus(edges, 1'b1);
        check_output("cks_boot_edges", 32'(edges), 32'd43);
        check_output("cks_err", 32'(err), 32'd0);
        check_output("cks_rom_addr", 32'(rom_addr), 32'd12);
        check_output("cks_region", 32'(region), 32'd3);
        check_pulses("cks", base, 1'b1);

        $display("[TB] checksum build: region 1 checksum off by one");
        rom[8] = 8'hBF;
        assert_reset_now();
        check_reset_state("cks_rst");
        repeat (2) @(posedge clk);
        base = pulse_cnt;
        apply_stimulus(edges, 1'b1);
        check_output("bad_err_edges", 32'(edges), 32'd33);
        check_output("bad_err", 32'(err), 32'd1);
        check_output("bad_n_booted", 32'(n_booted), 32'd1);
        repeat (100) @(posedge clk);
        #1;
        check_output("bad_hold_err", 32'(err), 32'd1);
        check_output("bad_hold_n_booted", 32'(n_booted), 32'd1);
        check_output("bad_hold_rom_addr", 32'(rom_addr), 32'd9);
        check_output("bad_hold_region", 32'(region), 32'd1);
        check_output("bad_hold_bits",
                     32'({rom_n_oe, control_n_we, mlu_slice_n_we, mlu_lookahead_n_we}), 32'hF);
        check_output("bad_pulse_count", 32'(pulse_cnt - base), 32'd7);
        check_output("bad_last_pulse_region", 32'(p_which[base + 6]), 32'd1);
`else
        $display("[TB] plain build: full copy");
        base = pulse_cnt;
        apply_stimulus(edges, 1'b0);
        check_output("boot_edges", 32'(edges), 32'd37);
        check_output("done_region", 32'(region), 32'd3);
        check_output("done_rom_addr", 32'(rom_addr), 32'd9);
        check_output("done_err", 32'(err), 32'd0);
        check_pulses("boot", base, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_output("done_hold_bits",
                     32'({rom_n_oe, control_n_we, mlu_slice_n_we, mlu_lookahead_n_we, n_booted}),
                     32'b11110);
        check_output("done_hold_pulses", 32'(pulse_cnt - base), 32'd9);

        $display("[TB] reset in the middle of region 1");
        assert_reset_now();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        edges = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (region == 2'd1 && addr == 17'd1) begin
                edges = i;
                break;
            end
        end
        check_output("reach_region1_addr1", 32'(edges != 0), 32'd1);
        #2 n_rst = 1'b0;
        #1 check_reset_state("mid_rst");
        repeat (3) @(posedge clk);
        base = pulse_cnt;
        apply_stimulus(edges, 1'b0);
        check_output("restart_edges", 32'(edges), 32'd37);
        check_pulses("restart", base, 1'b0);

        $display("[TB] reset from DONE and repeat");
        assert_reset_now();
        check_output("redo_n_booted", 32'(n_booted), 32'd1);
        check_output("redo_region", 32'(region), 32'd0);
        repeat (5) @(posedge clk);
        base = pulse_cnt;
        apply_stimulus(edges, 1'b0);
        check_output("redo_edges", 32'(edges), 32'd37);
        check_pulses("redo", base, 1'b0);
`endif

        repeat (3) @(posedge clk);
        check_output("strobe_overlap", 32'(overlap_cnt), 32'd0);
        check_output("strobe_width", 32'(wide_cnt), 32'd0);
        check_output("bus_stability", 32'(unstable_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
